// File: rtl/ctrl_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_step_sequencer
//  Purpose  : Hardwired T-step control sequencer for the bus datapath
//             (fetch T0-T2, execute T3+ for ld, ldi, st, add, br, halt).
//  Options  : MEM_HANDSHAKE_EN - Read/Write steps wait for mem_ready instead
//             of a fixed MEM_LAT hold.
//  Revision : 1.0  initial release
// ============================================================================
module ctrl_step_sequencer #(
    parameter int OPC_W    = 5,
    parameter int STEP_W   = 4,
    parameter int MEM_LAT  = 1,
    parameter int ALU_OP_W = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                run,
    input  logic                stop,
    input  logic [31:0]         ir,
    input  logic                con,
    input  logic                mem_ready,
    output logic [31:0]         ctrl,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [STEP_W-1:0]   step,
    output logic                busy,
    output logic                halted
);

    localparam logic [31:0] c_PCOUT  = 32'h0000_0001;
    localparam logic [31:0] c_MARIN  = 32'h0000_0002;
    localparam logic [31:0] c_INCPC  = 32'h0000_0004;
    localparam logic [31:0] c_READ   = 32'h0000_0008;
    localparam logic [31:0] c_MDRIN  = 32'h0000_0010;
    localparam logic [31:0] c_PCIN   = 32'h0000_0020;
    localparam logic [31:0] c_MDROUT = 32'h0000_0040;
    localparam logic [31:0] c_IRIN   = 32'h0000_0080;
    localparam logic [31:0] c_GRA    = 32'h0000_0100;
    localparam logic [31:0] c_GRB    = 32'h0000_0200;
    localparam logic [31:0] c_GRC    = 32'h0000_0400;
    localparam logic [31:0] c_RIN    = 32'h0000_0800;
    localparam logic [31:0] c_ROUT   = 32'h0000_1000;
    localparam logic [31:0] c_BAOUT  = 32'h0000_2000;
    localparam logic [31:0] c_YIN    = 32'h0000_4000;
    localparam logic [31:0] c_COUT   = 32'h0000_8000;
    localparam logic [31:0] c_ZIN    = 32'h0001_0000;
    localparam logic [31:0] c_ZLOOUT = 32'h0002_0000;
    localparam logic [31:0] c_CONIN  = 32'h0004_0000;
    localparam logic [31:0] c_WRITE  = 32'h0008_0000;

    localparam logic [OPC_W-1:0] c_OPC_LD   = OPC_W'(0);
    localparam logic [OPC_W-1:0] c_OPC_LDI  = OPC_W'(1);
    localparam logic [OPC_W-1:0] c_OPC_ST   = OPC_W'(2);
    localparam logic [OPC_W-1:0] c_OPC_ADD  = OPC_W'(3);
    localparam logic [OPC_W-1:0] c_OPC_BR   = OPC_W'(4);
    localparam logic [OPC_W-1:0] c_OPC_HALT = OPC_W'(5);

    localparam logic [3:0] c_HOLD_LAST = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [STEP_W-1:0]     r_step, w_step_nxt, w_step_inc;
    logic [OPC_W-1:0]      r_opc, w_opc_nxt, w_ir_opc;
    logic [3:0]            r_hold, w_hold_nxt;
    logic                  r_stop_seen, w_stop_nxt;
    logic                  w_is_read, w_is_write, w_stall, w_end;
    logic [31:0]           r_ctrl, w_ctrl_nxt;
    logic [ALU_OP_W-1:0]   r_alu_op, w_alu_nxt;
    logic                  r_busy, r_halted;
    logic                  w_unused;

    // Last T-step of each instruction; unknown opcodes finish after fetch.
    function automatic logic [STEP_W-1:0] f_last(input logic [OPC_W-1:0] o);
        case (o)
            c_OPC_LD:   return STEP_W'(7);
            c_OPC_LDI:  return STEP_W'(5);
            c_OPC_ST:   return STEP_W'(7);
            c_OPC_ADD:  return STEP_W'(5);
            c_OPC_BR:   return STEP_W'(6);
            c_OPC_HALT: return STEP_W'(3);
            default:    return STEP_W'(2);
        endcase
    endfunction

    function automatic logic [31:0] f_ctrl(input logic [STEP_W-1:0] s,
                                           input logic [OPC_W-1:0]  o,
                                           input logic              c);
        logic [31:0] v;
        v = '0;
        if (s == STEP_W'(0)) begin
            v = c_PCOUT | c_MARIN;
        end else if (s == STEP_W'(1)) begin
            v = c_READ | c_MDRIN | c_PCIN | c_INCPC;
        end else if (s == STEP_W'(2)) begin
            v = c_MDROUT | c_IRIN;
        end else begin
            case (o)
                c_OPC_LD, c_OPC_LDI, c_OPC_ST: begin
                    case (s)
                        STEP_W'(3): v = c_GRB | c_BAOUT | c_YIN;
                        STEP_W'(4): v = c_COUT | c_ZIN;
                        STEP_W'(5): v = (o == c_OPC_LDI) ? (c_ZLOOUT | c_GRA | c_RIN)
                                                         : (c_ZLOOUT | c_MARIN);
                        STEP_W'(6): v = (o == c_OPC_LD) ? (c_READ | c_MDRIN)
                                                        : (c_GRA | c_ROUT | c_MDRIN);
                        STEP_W'(7): v = (o == c_OPC_LD) ? (c_MDROUT | c_GRA | c_RIN)
                                                        : c_WRITE;
                        default:    v = '0;
                    endcase
                end
                c_OPC_ADD: begin
                    case (s)
                        STEP_W'(3): v = c_GRB | c_ROUT | c_YIN;
                        STEP_W'(4): v = c_GRC | c_ROUT | c_ZIN;
                        STEP_W'(5): v = c_ZLOOUT | c_GRA | c_RIN;
                        default:    v = '0;
                    endcase
                end
                c_OPC_BR: begin
                    case (s)
                        STEP_W'(3): v = c_GRA | c_ROUT | c_CONIN;
                        STEP_W'(4): v = c_PCOUT | c_YIN;
                        STEP_W'(5): v = c_COUT | c_ZIN;
                        STEP_W'(6): v = c ? (c_ZLOOUT | c_PCIN) : '0;
                        default:    v = '0;
                    endcase
                end
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    function automatic logic [ALU_OP_W-1:0] f_alu(input logic [STEP_W-1:0] s,
                                                  input logic [OPC_W-1:0]  o);
        logic add;
        case (o)
            c_OPC_LD, c_OPC_LDI, c_OPC_ST, c_OPC_ADD: add = (s == STEP_W'(4));
            c_OPC_BR:                                 add = (s == STEP_W'(5));
            default:                                  add = 1'b0;
        endcase
        return add ? ALU_OP_W'(1) : '0;
    endfunction

    assign w_ir_opc   = ir[31:32-OPC_W];
    assign w_step_inc = (r_step == '1) ? r_step : r_step + STEP_W'(1);
    assign w_is_read  = (r_step == STEP_W'(1)) ||
                        ((r_opc == c_OPC_LD) && (r_step == STEP_W'(6)));
    assign w_is_write = (r_opc == c_OPC_ST) && (r_step == STEP_W'(7));

`ifdef MEM_HANDSHAKE_EN
    assign w_stall = (w_is_read || w_is_write) && !mem_ready;
`else
    assign w_stall = w_is_read && (r_hold != c_HOLD_LAST);
`endif

    // Low opcode-free IR bits (and mem_ready in fixed-latency builds) are not decoded.
    assign w_unused = &{1'b0, ir[31-OPC_W:0], mem_ready, w_is_write};

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_opc_nxt   = r_opc;
        w_hold_nxt  = r_hold;
        w_stop_nxt  = r_stop_seen;
        w_end       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stop_nxt = 1'b0;
                w_hold_nxt = '0;
                w_step_nxt = '0;
                if (run) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                w_stop_nxt = r_stop_seen | stop;
                if (w_stall) begin
                    w_hold_nxt = r_hold + 4'd1;
                end else begin
                    w_hold_nxt = '0;
                    if (r_step == STEP_W'(2)) begin
                        if (f_last(w_ir_opc) == STEP_W'(2)) begin
                            w_end = 1'b1;
                        end else begin
                            w_step_nxt = STEP_W'(3);
                            w_opc_nxt  = w_ir_opc;
                        end
                    end else if ((r_step == STEP_W'(3)) && (r_opc == c_OPC_HALT)) begin
                        w_state_nxt = S_HALT;
                        w_step_nxt  = '0;
                    end else if ((r_step >= STEP_W'(3)) && (r_step == f_last(r_opc))) begin
                        w_end = 1'b1;
                    end else begin
                        w_step_nxt = w_step_inc;
                    end
                    // Instruction boundary: a stop seen at any point wins over run.
                    if (w_end) begin
                        w_step_nxt = '0;
                        if (!(run && !(r_stop_seen || stop))) begin
                            w_state_nxt = S_IDLE;
                            w_stop_nxt  = 1'b0;
                        end
                    end
                end
            end
            S_HALT: begin
                w_step_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        w_ctrl_nxt = '0;
        w_alu_nxt  = '0;
        if (w_state_nxt == S_STEP) begin
            w_ctrl_nxt = f_ctrl(w_step_nxt, w_opc_nxt, con);
            w_alu_nxt  = f_alu(w_step_nxt, w_opc_nxt);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_opc       <= '0;
            r_hold      <= '0;
            r_stop_seen <= 1'b0;
            r_ctrl      <= '0;
            r_alu_op    <= '0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_opc       <= w_opc_nxt;
            r_hold      <= w_hold_nxt;
            r_stop_seen <= w_stop_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_alu_op    <= w_alu_nxt;
            r_busy      <= (w_state_nxt == S_STEP);
            r_halted    <= (w_state_nxt == S_HALT);
        end
    end

    assign ctrl   = r_ctrl;
    assign alu_op = r_alu_op;
    assign step   = r_step;
    assign busy   = r_busy;
    assign halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_step_sequencer
//  Purpose  : Self-checking bench for ctrl_step_sequencer (MEM_LAT 1 and 3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_step_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        run = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] ir = '0;
    logic        con = 1'b0;
    logic        mem_ready = 1'b0;

    logic [31:0] d_ctrl   [2];
    logic [3:0]  d_alu    [2];
    logic [3:0]  d_step   [2];
    logic        d_busy   [2];
    logic        d_halted [2];

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    ctrl_step_sequencer #(.OPC_W(5), .STEP_W(4), .MEM_LAT(1), .ALU_OP_W(4)) u_dut0 (
        .Clock(Clock), .Reset(Reset), .run(run), .stop(stop), .ir(ir), .con(con),
        .mem_ready(mem_ready), .ctrl(d_ctrl[0]), .alu_op(d_alu[0]), .step(d_step[0]),
        .busy(d_busy[0]), .halted(d_halted[0])
    );

    ctrl_step_sequencer #(.OPC_W(5), .STEP_W(4), .MEM_LAT(3), .ALU_OP_W(4)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .run(run), .stop(stop), .ir(ir), .con(con),
        .mem_ready(mem_ready), .ctrl(d_ctrl[1]), .alu_op(d_alu[1]), .step(d_step[1]),
        .busy(d_busy[1]), .halted(d_halted[1])
    );

    // Reference model: mode 0 idle, 1 running, 2 halted.
    int c_lat   [2] = '{1, 3};
    int m_mode  [2] = '{0, 0};
    int m_step  [2] = '{0, 0};
    int m_dwell [2] = '{0, 0};
    int m_opc   [2] = '{0, 0};
    bit m_stop  [2] = '{0, 0};
    bit m_taken [2] = '{0, 0};

    // Number of execute steps after fetch; 0 means the opcode is a nop.
    function automatic int n_exec(input int opc);
        case (opc)
            0: return 5;
            1: return 3;
            2: return 5;
            3: return 3;
            4: return 4;
            5: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] exp_ctrl_of(input int opc, input int stp, input bit taken);
        logic [31:0] seq [8];
        seq = '{default: 32'h0};
        seq[0] = 32'h3; seq[1] = 32'h3C; seq[2] = 32'hC0;
        case (opc)
            0: begin seq[3] = 32'h6200; seq[4] = 32'h18000; seq[5] = 32'h20002;
                     seq[6] = 32'h18;   seq[7] = 32'h940; end
            1: begin seq[3] = 32'h6200; seq[4] = 32'h18000; seq[5] = 32'h20900; end
            2: begin seq[3] = 32'h6200; seq[4] = 32'h18000; seq[5] = 32'h20002;
                     seq[6] = 32'h1110; seq[7] = 32'h80000; end
            3: begin seq[3] = 32'h5200; seq[4] = 32'h11400; seq[5] = 32'h20900; end
            4: begin seq[3] = 32'h41100; seq[4] = 32'h4001; seq[5] = 32'h18000;
                     seq[6] = taken ? 32'h20020 : 32'h0; end
            default: ;
        endcase
        return seq[stp];
    endfunction

    task automatic upd(input int d);
        bit fin;
        int iro;
        fin = 1'b0;
        iro = int'(ir[31:27]);
        if (!Reset) begin
            m_mode[d] = 0; m_step[d] = 0; m_dwell[d] = 0; m_stop[d] = 1'b0;
        end else if (m_mode[d] == 0) begin
            if (run) begin m_mode[d] = 1; m_step[d] = 0; m_dwell[d] = 1; end
        end else if (m_mode[d] == 1) begin
            m_stop[d] = m_stop[d] | stop;
            if ((m_step[d] == 1 || (m_opc[d] == 0 && m_step[d] == 6)) && m_dwell[d] < c_lat[d])
                m_dwell[d]++;
            else if (m_step[d] == 2 && n_exec(iro) == 0)
                fin = 1'b1;
            else if (m_step[d] == 2) begin
                m_opc[d] = iro; m_step[d] = 3; m_dwell[d] = 1;
            end else if (m_step[d] >= 3 && m_opc[d] == 5)
                m_mode[d] = 2;
            else if (m_step[d] == 2 + n_exec(m_opc[d]))
                fin = 1'b1;
            else begin
                m_step[d]++; m_dwell[d] = 1;
                if (m_step[d] == 6) m_taken[d] = con;
            end
            if (fin) begin
                if (run && !m_stop[d]) begin
                    m_step[d] = 0; m_dwell[d] = 1;
                end else begin
                    m_mode[d] = 0; m_stop[d] = 1'b0;
                end
            end
        end
    endtask

    always @(posedge Clock) begin
        upd(0);
        upd(1);
    end

    always @(negedge Clock) begin
        logic [31:0] ec;
        logic [41:0] ev, av;
        for (int d = 0; d < 2; d++) begin
            ec = '0;
            ev = '0;
            if (m_mode[d] == 1) begin
                ec = exp_ctrl_of(m_opc[d], m_step[d], m_taken[d]);
                ev = {ec, 3'b000, ec[16], 4'(m_step[d]), 1'b1, 1'b0};
            end else if (m_mode[d] == 2) begin
                ev = {32'h0, 4'h0, 4'h0, 1'b0, 1'b1};
            end
            av = {d_ctrl[d], d_alu[d], d_step[d], d_busy[d], d_halted[d]};
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL model_dut%0d t=%0t actual={ctrl,alu,step,busy,halted}=0x%0h required=0x%0h",
                         d, $time, av, ev);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clock);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && (d_busy[0] || d_busy[1]); i++) cyc();
        chk("idle_timeout", {31'b0, d_busy[0] | d_busy[1]}, 32'h0);
    endtask

    initial begin
        int cnt;
        int hcnt;
        repeat (2) cyc();
        chk("reset_ctrl", d_ctrl[0], 32'h0);
        chk("reset_busy", {31'b0, d_busy[0]}, 32'h0);

        // ldi through both DUTs
        Reset = 1'b1; ir = 32'h0880_0075; run = 1'b1;
        cyc(); run = 1'b0;
        chk("ldi_t0", d_ctrl[0], 32'h3);
        cyc(); chk("ldi_t1", d_ctrl[0], 32'h3C);
        cyc(); chk("ldi_t2", d_ctrl[0], 32'hC0);
        cyc(); chk("ldi_t3", d_ctrl[0], 32'h6200);
        cyc(); chk("ldi_t4", d_ctrl[0], 32'h18000);
        chk("ldi_t4_alu", {28'b0, d_alu[0]}, 32'h1);
        cyc(); chk("ldi_t5", d_ctrl[0], 32'h20900);
        cyc(); chk("ldi_end_busy", {31'b0, d_busy[0]}, 32'h0);
        chk("ldi_end_ctrl", d_ctrl[0], 32'h0);
        wait_idle();

        // ld length with MEM_LAT=3
        ir = 32'h0012_3456; run = 1'b1;
        cyc(); run = 1'b0;
        cnt = 0;
        while (d_busy[1] && cnt < 40) begin cnt++; cyc(); end
        chk("ld_lat3_len", 32'(cnt), 32'd12);
        wait_idle();

        // br not taken, then taken
        ir = 32'h2000_0000; con = 1'b0; run = 1'b1;
        cyc(); run = 1'b0;
        repeat (6) cyc();
        chk("br_nt_step", {28'b0, d_step[0]}, 32'd6);
        chk("br_nt_t6", d_ctrl[0], 32'h0);
        wait_idle();
        con = 1'b1; run = 1'b1;
        cyc(); run = 1'b0;
        repeat (6) cyc();
        chk("br_tk_t6", d_ctrl[0], 32'h20020);
        con = 1'b0;
        wait_idle();

        // Reset mid-ld
        ir = 32'h0000_0000; run = 1'b1;
        cyc(); run = 1'b0;
        cyc(); cyc();
        Reset = 1'b0;
        cyc(); cyc();
        Reset = 1'b1;
        chk("rst_mid_ctrl", d_ctrl[1], 32'h0);
        chk("rst_mid_step", {28'b0, d_step[1]}, 32'h0);
        chk("rst_mid_busy", {31'b0, d_busy[1]}, 32'h0);
        repeat (3) cyc();
        chk("rst_stays_idle", {31'b0, d_busy[0]}, 32'h0);

        // halt with run held
        ir = 32'h2800_0000; run = 1'b1;
        cnt = 0;
        while (!d_halted[0] && cnt < 20) begin cnt++; cyc(); end
        chk("halt_set", {31'b0, d_halted[0]}, 32'h1);
        chk("halt_busy", {31'b0, d_busy[0]}, 32'h0);
        repeat (5) cyc();
        chk("halt_sticky", {31'b0, d_halted[0]}, 32'h1);
        chk("halt_ctrl", d_ctrl[0], 32'h0);
        Reset = 1'b0; run = 1'b0;
        cyc();
        Reset = 1'b1;
        chk("halt_cleared", {31'b0, d_halted[0]}, 32'h0);

        // Randomised phase
        hcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] opc;
            opc = 5'($urandom_range(0, 7));
            if (opc == 5'd5 && $urandom_range(0, 3) != 0) opc = 5'd1;
            ir        = {opc, 27'($urandom)};
            run       = ($urandom_range(0, 99) < 85);
            stop      = ($urandom_range(0, 99) < 5);
            con       = 1'($urandom);
            mem_ready = 1'($urandom);
            Reset     = ($urandom_range(0, 199) != 0);
            if (m_mode[0] == 2 || m_mode[1] == 2) hcnt++;
            if (hcnt > 8) begin Reset = 1'b0; hcnt = 0; end
            cyc();
        end
        run = 1'b0; stop = 1'b0;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_step_sequencer.md
Name: ctrl_step_sequencer

Overview:
- Hardwired control-step sequencer that replaces hand-sequenced T-state stimulus for the bus datapath.
- Drives every datapath control strobe for fetch (T0-T2) and execute (T3 onward) for ld, ldi, st, add, br and halt.
- Generalised over opcode width, memory latency and step-counter width.
- Sits between IR/CON flag and the datapath control inputs; one control step per clock.

Parameters:
- OPC_W, 5, opcode width taken from ir[31:32-OPC_W].
- STEP_W, 4, step-counter width; must hold values up to 7.
- MEM_LAT, 1, clocks each Read step is held, fixed-latency mode only; legal range 1-15.
- ALU_OP_W, 4, width of alu_op.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous active-low reset.
- run  in  1  start or resume sequencing.
- stop  in  1  stop after the current instruction.
- ir  in  32  IR register contents.
- con  in  1  CON flip-flop output.
- mem_ready  in  1  memory ready; used only with MEM_HANDSHAKE_EN.
- ctrl  out  32  control-strobe bus, bit map in Behaviour.
- alu_op  out  ALU_OP_W  ALU operation: 0 = pass, 1 = ADD.
- step  out  STEP_W  current T-step number.
- busy  out  1  instruction in progress.
- halted  out  1  halt executed.

Behaviour:
- ctrl bit map: 0 PCout, 1 MARin, 2 IncPC, 3 Read, 4 MDRin, 5 PCin, 6 MDRout, 7 IRin, 8 Gra, 9 Grb, 10 Grc, 11 Rin, 12 Rout, 13 BAout, 14 Yin, 15 Cout, 16 Zin, 17 ZLOout, 18 CONin, 19 Write.
- Bits 31:20 are always 0.
- All outputs are registered and reflect the current step.
- Reset low at a clock edge: state IDLE, ctrl=0, alu_op=0, step=0, busy=0, halted=0. Reset aborts any instruction mid-step.
- States: IDLE, STEP, HALT.
- IDLE: outputs 0. If run=1 at the edge, go to STEP with step=0 and busy=1.
- Fetch steps:
  - T0: PCout, MARin.
  - T1: Read, MDRin, PCin, IncPC.
  - T2: MDRout, IRin.
- Opcode is sampled from ir at the T3 entry edge.
- Opcode map: 0 ld, 1 ldi, 2 st, 3 add, 4 br, 5 halt. Any other value is a nop and ends after T2.
- ld: T3 Grb+BAout+Yin; T4 Cout+Zin with alu_op=1; T5 ZLOout+MARin; T6 Read+MDRin; T7 MDRout+Gra+Rin.
- ldi: T3 and T4 as ld; T5 ZLOout+Gra+Rin.
- st: T3 and T4 as ld; T5 ZLOout+MARin; T6 Gra+Rout+MDRin with Read=0; T7 Write.
- add: T3 Grb+Rout+Yin; T4 Grc+Rout+Zin with alu_op=1; T5 ZLOout+Gra+Rin.
- br: T3 Gra+Rout+CONin; T4 PCout+Yin; T5 Cout+Zin with alu_op=1; T6 ZLOout+PCin only if con=1 at that edge, otherwise ctrl=0 for T6.
- halt: T3 asserts no strobes. Next state is HALT with halted=1 and busy=0. HALT is left only by reset.
- Read steps (T1, ld T6) are held for MEM_LAT clocks; step does not advance during the hold and strobes stay asserted.
- End of instruction: from the last step, return to T0 if run=1 and stop has not been seen. Otherwise go to IDLE with busy=0.
- stop is latched whenever it is seen during an instruction and cleared on entry to IDLE.
- run and stop high in the same cycle: stop wins at the instruction boundary.
- step saturates at 2^STEP_W-1 and never wraps.

Optional Feature:
- Macro MEM_HANDSHAKE_EN.
- Defined: each Read step holds until mem_ready=1 is sampled; the step advances on the edge after that sample; MEM_LAT is ignored. st T7 Write also waits for mem_ready.
- Undefined: fixed MEM_LAT hold; mem_ready is ignored. The Write step lasts 1 clock.

Test Plan:
- Reset low for 2 clocks mid-ld, then high -> ctrl=0, step=0, busy=0; stays IDLE until run pulses.
- MEM_LAT=1, ir=0x08800075 (ldi), run pulse -> T0 ctrl=0x3, T1 0x3C, T2 0xC0, T3 0x6200, T4 0x18000 with alu_op=1, T5 0x20900; then IDLE.
- ld with MEM_LAT=3 -> T1 and T6 each last 3 clocks; total 12 clocks from T0 to IDLE.
- br with con=0 -> T6 ctrl=0; with con=1 -> T6 ctrl=0x20020.
- run held, halt opcode (ir[31:27]=5) -> halted=1 after T3; further run ignored until reset.
- MEM_HANDSHAKE_EN defined, mem_ready low 5 clocks at T1 -> step stays 1 with ctrl=0x3C for 5 clocks, advances one clock after mem_ready=1.
